// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target register file: FSM states and
// the general-call address/command constants.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RD_MACK,
        WAIT_STOP
    } i2c_state_e;

    localparam logic [6:0] GEN_CALL_ADDR = 7'h00;
    localparam logic [7:0] SOFT_RST_CMD  = 8'h06;

endpackage

// File: rtl/i2c_bus_filter.sv
// SCL/SDA front end: 2-flop synchroniser, FILT_LEN-cycle stability filter,
// and single-cycle SCL edge / START / STOP pulses from the filtered levels.
module i2c_bus_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic bus_start,
    output logic bus_stop
);

    localparam int CW = $clog2(FILT_LEN + 1);

    // bit 1 = SCL, bit 0 = SDA
    logic [1:0]    sync1, sync2, filt, prev;
    logic [CW-1:0] cnt [2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '1;
            sync2 <= '1;
            filt  <= '1;
            prev  <= '1;
            for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sync1 <= {scl_i, sda_i};
            sync2 <= sync1;
            prev  <= filt;
            // A new level is accepted only after FILT_LEN consecutive differing samples.
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(FILT_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign sda       = filt[0];
    assign scl_rise  = filt[1] & ~prev[1];
    assign scl_fall  = ~filt[1] & prev[1];
    assign bus_start = filt[1] & prev[1] & prev[0] & ~filt[0];
    assign bus_stop  = filt[1] & prev[1] & ~prev[0] & filt[0];

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing 2**ADDR_W byte registers behind an auto-incrementing pointer.
// Optional I2C_GEN_CALL_EN: general-call write of SOFT_RST_CMD reloads all registers.
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter int         ADDR_W   = 4,
    parameter int         FILT_LEN = 3,
    parameter logic [7:0] RST_VAL  = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    input  logic [6:0]        slave_addr,
    input  logic [ADDR_W-1:0] loc_rd_addr,
    output logic [7:0]        loc_rd_data,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic sda, scl_rise, scl_fall, bus_start, bus_stop;

    i2c_bus_filter #(.FILT_LEN(FILT_LEN)) u_filter (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .bus_start (bus_start),
        .bus_stop  (bus_stop)
    );

    i2c_state_e        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, wr_addr_d;
    logic [7:0]        wr_data_d, rd_byte, byte_in;
    logic              oe_d, wstb_d, gc_q, gc_d, srst_q, srst_d, byte_done;
    logic [7:0]        regs [DEPTH];

    assign byte_in     = {shift_q[6:0], sda};
    assign byte_done   = scl_rise && (cnt_q == 3'd7);
    assign rd_byte     = regs[ptr_q];
    assign loc_rd_data = regs[loc_rd_addr];
    assign busy        = !(state_q inside {IDLE, ADDR, WAIT_STOP});

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        oe_d      = sda_oe;
        wstb_d    = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        gc_d      = gc_q;
        srst_d    = 1'b0;

        if (bus_stop) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            cnt_d   = '0;
            gc_d    = 1'b0;
        end else if (bus_start) begin
            state_d = ADDR;
            oe_d    = 1'b0;
            cnt_d   = '0;
            gc_d    = 1'b0;
        end else begin
            if (scl_rise && (state_q inside {ADDR, PTR, WDATA})) begin
                shift_d = byte_in;
                cnt_d   = cnt_q + 3'd1;
            end
            // ACK states use cnt as phase: first SCL fall drives ACK, second releases it.
            unique case (state_q)
                IDLE, WAIT_STOP: ;
                ADDR: if (byte_done) begin
                    if (byte_in[7:1] != GEN_CALL_ADDR && byte_in[7:1] == slave_addr)
                        state_d = ADDR_ACK;
`ifdef I2C_GEN_CALL_EN
                    else if (byte_in == {GEN_CALL_ADDR, 1'b0}) begin
                        state_d = ADDR_ACK;
                        gc_d    = 1'b1;
                    end
`endif
                    else
                        state_d = WAIT_STOP;
                end
                PTR: if (byte_done) begin
                    if (!gc_q) begin
                        ptr_d   = byte_in[ADDR_W-1:0];
                        state_d = PTR_ACK;
                    end else if (byte_in == SOFT_RST_CMD) begin
                        srst_d  = 1'b1;
                        ptr_d   = '0;
                        state_d = PTR_ACK;
                    end else begin
                        state_d = WAIT_STOP;
                    end
                end
                WDATA: if (byte_done) begin
                    wstb_d    = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = byte_in;
                    ptr_d     = ptr_q + 1'b1;
                    state_d   = WDATA_ACK;
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                    if (cnt_q == 3'd0) begin
                        oe_d  = 1'b1;
                        cnt_d = 3'd1;
                    end else begin
                        oe_d  = 1'b0;
                        cnt_d = '0;
                        if (state_q == ADDR_ACK && shift_q[0]) begin
                            shift_d = rd_byte;
                            oe_d    = ~rd_byte[7];
                            state_d = RDATA;
                        end else if (state_q == ADDR_ACK)
                            state_d = PTR;
                        else if (state_q == PTR_ACK && gc_q)
                            state_d = WAIT_STOP;
                        else
                            state_d = WDATA;
                    end
                end
                RDATA: if (scl_fall) begin
                    if (cnt_q == 3'd7) begin
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        shift_d = '1;
                        ptr_d   = ptr_q + 1'b1;
                        state_d = RD_MACK;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                        oe_d    = ~shift_q[6];
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
                RD_MACK: begin
                    if (scl_rise) shift_d[0] = sda;
                    if (scl_fall) begin
                        if (!shift_q[0]) begin
                            shift_d = rd_byte;
                            oe_d    = ~rd_byte[7];
                            cnt_d   = '0;
                            state_d = RDATA;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            sda_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            gc_q      <= 1'b0;
            srst_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_oe    <= oe_d;
            wr_strobe <= wstb_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
            gc_q      <= gc_d;
            srst_q    <= srst_d;
        end
    end

    // Array commits at the end of the wr_strobe cycle, so local reads in that cycle see the old byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= RST_VAL;
        end else if (srst_q) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= RST_VAL;
        end else if (wr_strobe) begin
            regs[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Randomised bus-master bench for i2c_target_regfile against an array/pointer reference model.
module tb_i2c_target_regfile;

    localparam int         AW    = 4;
    localparam int         DEPTH = 1 << AW;
    localparam int         Q     = 10;
    localparam logic [7:0] RV    = 8'h3C;
    localparam logic [6:0] SA    = 7'h2A;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          scl = 1'b1;
    logic          sda_m = 1'b1;
    logic          sda_oe, wr_strobe, busy, sda_line;
    logic [AW-1:0] wr_addr, loc_rd_addr;
    logic [7:0]    wr_data, loc_rd_data;

    int checks = 0;
    int errors = 0;
    int mem [DEPTH];
    int mptr;
    int oe_viol;
    bit watch_oe;
    logic [AW+7:0] got_q [$];

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regfile #(.ADDR_W(AW), .FILT_LEN(3), .RST_VAL(RV)) dut (
        .clk         (clk),
        .reset       (reset),
        .scl_i       (scl),
        .sda_i       (sda_line),
        .sda_oe      (sda_oe),
        .slave_addr  (SA),
        .loc_rd_addr (loc_rd_addr),
        .loc_rd_data (loc_rd_data),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy)
    );

    always @(negedge clk) begin
        if (wr_strobe) got_q.push_back({wr_addr, wr_data});
        if (watch_oe && sda_oe) oe_viol++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = RV;
        mptr = 0;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            loc_rd_addr = AW'(i);
            #1;
            check($sformatf("%s_reg%0d", tag, i), loc_rd_data, mem[i]);
        end
    endtask

    task automatic i2c_start();
        wait_q(); sda_m = 1'b1;
        wait_q(); scl = 1'b1;
        wait_q(); sda_m = 1'b0;
        wait_q(); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_q(); sda_m = 1'b0;
        wait_q(); scl = 1'b1;
        wait_q(); sda_m = 1'b1;
        wait_q();
    endtask

    task automatic clk_bit(input logic b, output logic seen);
        wait_q(); sda_m = b;
        wait_q(); scl = 1'b1;
        wait_q(); seen = sda_line;
        wait_q(); scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input bit mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            b[i] = s;
        end
        clk_bit(mack ? 1'b0 : 1'b1, s);
    endtask

    task automatic do_write(input logic [7:0] pbyte, input logic [7:0] d [$]);
        logic          ack;
        logic [AW+7:0] exp_q [$];
        got_q.delete();
        i2c_start();
        write_byte({SA, 1'b0}, ack); check("w_addr_ack", ack, 1);
        write_byte(pbyte, ack);      check("w_ptr_ack", ack, 1);
        mptr = pbyte % DEPTH;
        foreach (d[i]) begin
            write_byte(d[i], ack); check("w_data_ack", ack, 1);
            mem[mptr] = d[i];
            exp_q.push_back({AW'(mptr), d[i]});
            mptr = (mptr + 1) % DEPTH;
        end
        i2c_stop();
        check("w_busy_idle", busy, 0);
        check("w_strobe_cnt", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("w_strobe_addr_data", got_q[i], exp_q[i]);
    endtask

    task automatic do_read(input bit setp, input logic [7:0] pbyte, input int n);
        logic       ack;
        logic [7:0] b;
        i2c_start();
        if (setp) begin
            write_byte({SA, 1'b0}, ack); check("r_waddr_ack", ack, 1);
            write_byte(pbyte, ack);      check("r_ptr_ack", ack, 1);
            mptr = pbyte % DEPTH;
            i2c_start();
        end
        write_byte({SA, 1'b1}, ack); check("r_addr_ack", ack, 1);
        check("r_busy", busy, 1);
        for (int i = 0; i < n; i++) begin
            read_byte(i != n - 1, b);
            check("r_data", b, mem[mptr]);
            mptr = (mptr + 1) % DEPTH;
        end
        i2c_stop();
        check("r_busy_idle", busy, 0);
    endtask

    initial begin
        logic       ack, s;
        logic [7:0] d [$];
        int         n;
        logic [7:0] pb;

        loc_rd_addr = '0;
        watch_oe    = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check_regs("rst");

        // basic write then repeated-start read
        d.delete(); d.push_back(8'hA5); d.push_back(8'h5A);
        do_write(8'h03, d);
        check_regs("wr");
        do_read(1'b1, 8'h03, 2);

        // pointer wrap
        d.delete(); d.push_back(8'h11); d.push_back(8'h22);
        do_write(8'h0F, d);
        check_regs("wrap");

        // address mismatch: never driven, no strobes
        got_q.delete(); oe_viol = 0; watch_oe = 1'b1;
        i2c_start();
        write_byte(8'h56, ack); check("mm_addr_nack", ack, 0);
        write_byte(8'h00, ack); check("mm_ignored", ack, 0);
        i2c_stop();
        watch_oe = 1'b0;
        check("mm_oe", oe_viol, 0);
        check("mm_strobe", got_q.size(), 0);
        check("mm_busy", busy, 0);

        // 1-clk SCL glitch inside a write byte
        got_q.delete();
        i2c_start();
        write_byte({SA, 1'b0}, ack); check("gl_addr_ack", ack, 1);
        write_byte(8'h07, ack);      check("gl_ptr_ack", ack, 1);
        mptr = 7;
        wait_q(); scl = 1'b1; @(negedge clk); scl = 1'b0;
        write_byte(8'hC3, ack);      check("gl_data_ack", ack, 1);
        mem[7] = 8'hC3; mptr = 8;
        i2c_stop();
        check("gl_strobe_cnt", got_q.size(), 1);
        if (got_q.size() > 0) check("gl_strobe", got_q[0], {4'h7, 8'hC3});

        // STOP after 4 data bits: partial byte discarded
        got_q.delete();
        i2c_start();
        write_byte({SA, 1'b0}, ack); check("ab_addr_ack", ack, 1);
        write_byte(8'h09, ack);      check("ab_ptr_ack", ack, 1);
        mptr = 9;
        clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b1, s);
        i2c_stop();
        check("ab_strobe", got_q.size(), 0);
        check("ab_busy", busy, 0);
        check_regs("abort");

        // general call
        i2c_start();
        write_byte({i2c_pkg::GEN_CALL_ADDR, 1'b0}, ack);
`ifdef I2C_GEN_CALL_EN
        check("gc_addr_ack", ack, 1);
        write_byte(i2c_pkg::SOFT_RST_CMD, ack);
        check("gc_cmd_ack", ack, 1);
        i2c_stop();
        model_reset();
`else
        check("gc_addr_nack", ack, 0);
        i2c_stop();
`endif
        check_regs("gc");
        do_read(1'b0, 8'h00, 2);

        // reset while the target is driving ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            pb = {SA, 1'b0};
            clk_bit(pb[i], s);
        end
        wait_q(); sda_m = 1'b1;
        wait_q(); scl = 1'b1;
        wait_q();
        check("rm_ack_driven", sda_oe, 1);
        reset = 1'b0;
        #1;
        check("rm_async_release", sda_oe, 0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_q(); scl = 1'b0;
        i2c_stop();
        check("rm_busy", busy, 0);
        check_regs("rm");

        // randomised transactions
        for (int k = 0; k < 8; k++) begin
            n  = int'($urandom_range(1, 4));
            pb = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                d.delete();
                repeat (n) d.push_back(8'($urandom));
                do_write(pb, d);
            end else begin
                do_read($urandom_range(0, 1) == 1, pb, n);
            end
        end
        check_regs("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target_regfile.md
I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning register-pointer width; DEPTH = 2**ADDR_W byte registers, legal range 1..8.
REQ-002 SHALL have parameter FILT_LEN, default 3, meaning clk cycles an SCL/SDA level must be stable before it is accepted (glitch filter).
REQ-003 SHALL have parameter RST_VAL, default 8'h00, meaning reset value of every register byte.
REQ-004 Ports: clk  in  1  system clock; all logic on its rising edge.
REQ-005 Ports: reset  in  1  asynchronous, active-low reset.
REQ-006 Ports: scl_i  in  1  raw SCL; sda_i  in  1  raw SDA.
REQ-007 Ports: sda_oe  out  1  open-drain drive; 1 pulls SDA low, 0 releases the line.
REQ-008 Ports: slave_addr  in  7  own 7-bit address; held static while busy=1.
REQ-009 Ports: loc_rd_addr  in  ADDR_W  and  loc_rd_data  out  8  combinational local read of any register.
REQ-010 Ports: wr_strobe  out  1  one-cycle pulse per bus-written byte; wr_addr  out  ADDR_W;  wr_data  out  8.
REQ-011 Ports: busy  out  1  high from own-address ACK until STOP, repeated START, or NACK completion.

Function
REQ-012 SHALL pass scl_i/sda_i through a 2-flop synchroniser and then the FILT_LEN filter; all protocol logic uses filtered levels only.
REQ-013 START = filtered SDA 1->0 while SCL=1; STOP = SDA 0->1 while SCL=1; both are recognised in every state.
REQ-014 Data bits SHALL be sampled on the SCL rising edge, MSB first; sda_oe SHALL change only on the cycle after an SCL falling edge.
REQ-015 FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, WAIT_STOP.
REQ-016 IDLE->ADDR on START; START in any other state -> ADDR (repeated start), bit counter cleared, pointer retained.
REQ-017 ADDR: after 8 bits, addr[7:1]==slave_addr -> ADDR_ACK; else -> WAIT_STOP with sda_oe=0 (no ACK).
REQ-018 R/W bit = 0 is write: ADDR_ACK->PTR; R/W = 1 is read: ADDR_ACK->RDATA.
REQ-019 PTR: first written byte loads pointer with byte[ADDR_W-1:0]; upper bits ignored; ACK; ->WDATA.
REQ-020 WDATA: each byte writes reg[ptr], pulses wr_strobe with wr_addr=ptr and wr_data=byte in the same cycle, ACKs, ptr increments.
REQ-021 RDATA: drives reg[ptr] MSB first (sda_oe = ~bit); byte is latched into a shift register on SCL falling edge ending the ACK slot; ptr increments after each byte.
REQ-022 RD_MACK: sda_oe=0; master ACK (SDA=0) -> RDATA next byte; master NACK -> WAIT_STOP.
REQ-023 Pointer SHALL wrap modulo DEPTH (DEPTH-1 -> 0) on both read and write.
REQ-024 STOP in any state -> IDLE, sda_oe=0 within 2 clk cycles; a STOP mid-byte discards the partial byte without any register write.
REQ-025 Register updates from wr_strobe and loc_rd_data reads in the same cycle: loc_rd_data returns the pre-write value.

Reset
REQ-026 On reset low: state=IDLE, sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, ptr=0, all registers=RST_VAL, filters/synchronisers=1.
REQ-027 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously) and ignore the bus until the next START.

Configuration
REQ-028 Macro I2C_GEN_CALL_EN: when defined, address 7'h00 with W is ACKed; data byte 8'h06 then reloads all registers to RST_VAL and ptr=0, other bytes are NACKed.
REQ-029 Without I2C_GEN_CALL_EN, address 7'h00 is treated as any non-matching address (no ACK, WAIT_STOP).

Structure
REQ-030 Package i2c_pkg SHALL hold the FSM state enumeration, GEN_CALL_ADDR=7'h00 and SOFT_RST_CMD=8'h06.
REQ-031 One sub-module i2c_bus_filter SHALL implement synchroniser, glitch filter and START/STOP/SCL-edge pulse detection.

Verification
REQ-032 Write: slave_addr=7'h2A; START, 8'h54, ptr 8'h03, data 8'hA5, 8'h5A, STOP -> ACK on all 4 bytes, reg[3]=A5, reg[4]=5A, two wr_strobe pulses.
REQ-033 Read with repeated start: write ptr 8'h03, Sr, 8'h55, master ACK then NACK -> bytes A5, 5A driven, busy drops after STOP.
REQ-034 Wrap: ADDR_W=4, ptr 8'h0F, write 8'h11, 8'h22 -> reg[15]=11, reg[0]=22.
REQ-035 Mismatch: START, 8'h56 -> no ACK (sda_oe=0 throughout), no wr_strobe, bus ignored until STOP.
REQ-036 Glitch/abort: 1-clk SCL glitch (FILT_LEN=3) ignored; STOP after 4 data bits -> no register change, state IDLE.
REQ-037 With I2C_GEN_CALL_EN: START, 8'h00, 8'h06 -> both ACKed, all registers=RST_VAL; without it 8'h00 is NACKed.
